// File: rtl/majority_window_sampler_if.sv
// ---------------------------------------------------------------------------
// majority_window_sampler_if
//   Bundles the serial-input controls and the window handshake of the
//   majority window sampler so they travel as one port.
//
//   Signals
//     enable       1 = sample, 0 = idle and drop any partial window
//     din          serial data being oversampled
//     win_ready    consumer accepts the window on win_valid && win_ready
//     clr_overrun  synchronous clear of the sticky overrun flag
//     win          packed window, win[3] oldest sample ... win[0] newest
//     win_valid    win/vote/ones hold a window not yet accepted
//     vote         1 when at least three of the four samples are 1
//     ones         population count of win (0..4)
//     overrun      sticky flag, a completed window was dropped
//
//   Modports
//     master  the sampler, which produces the window
//     slave   the feeder/consumer side, which drives the controls
// ---------------------------------------------------------------------------
interface majority_window_sampler_if;
    logic       enable;
    logic       din;
    logic       win_ready;
    logic       clr_overrun;
    logic [3:0] win;
    logic       win_valid;
    logic       vote;
    logic [2:0] ones;
    logic       overrun;

    modport master (
        input  enable, din, win_ready, clr_overrun,
        output win, win_valid, vote, ones, overrun
    );

    modport slave (
        output enable, din, win_ready, clr_overrun,
        input  win, win_valid, vote, ones, overrun
    );
endinterface

// File: rtl/majority_window_sampler.sv
// ---------------------------------------------------------------------------
// majority_window_sampler
//   Oversamples a 1-bit serial input once every DIV clocks and packs four
//   consecutive samples into a window. The window is offered downstream on a
//   valid/ready handshake together with a registered 3-of-4 majority vote and
//   a ones count. A window that completes while the previous one is still
//   waiting is dropped and raises a sticky overrun flag.
//
//   Parameters
//     DIV    clocks between samples (1 .. 2**CNT_W)
//     CNT_W  width of the sample-interval divider counter
//
//   Ports
//     clk    rising-edge clock
//     rst    synchronous active-high reset, overrides every other input
//     bus    majority_window_sampler_if.master (controls in, window out)
// ---------------------------------------------------------------------------
module majority_window_sampler #(
    parameter int DIV   = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    majority_window_sampler_if.master  bus
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] div_cnt_q,   div_cnt_d;
    logic [1:0]       samp_cnt_q,  samp_cnt_d;
    logic [2:0]       stage_q,     stage_d;
    logic [3:0]       win_q,       win_d;
    logic             win_valid_q, win_valid_d;
    logic             vote_q,      vote_d;
    logic [2:0]       ones_q,      ones_d;
    logic             overrun_q,   overrun_d;

    logic             complete;
    logic [3:0]       new_win;
    logic [2:0]       new_ones;

    function automatic logic [2:0] count_ones(input logic [3:0] w);
        return 3'(w[3]) + 3'(w[2]) + 3'(w[1]) + 3'(w[0]);
    endfunction

    // The completing window is the three staged samples plus the live din,
    // so it can be registered on the same edge as the fourth sample.
    assign new_win  = {stage_q, bus.din};
    assign new_ones = count_ones(new_win);

    // Next-state logic: sampling FSM first, then the output handshake.
    // Overrun is cleared before the completion logic so that a drop in the
    // same cycle as clr_overrun still leaves the flag set.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        samp_cnt_d  = samp_cnt_q;
        stage_d     = stage_q;
        win_d       = win_q;
        win_valid_d = win_valid_q;
        vote_d      = vote_q;
        ones_d      = ones_q;
        overrun_d   = overrun_q;
        complete    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d    = FILL;
                    div_cnt_d  = '0;
                    samp_cnt_d = '0;
                    stage_d    = '0;
                end
            end
            FILL: begin
                if (!bus.enable) begin
                    state_d    = IDLE;
                    div_cnt_d  = '0;
                    samp_cnt_d = '0;
                    stage_d    = '0;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d  = '0;
                    samp_cnt_d = samp_cnt_q + 2'd1;
                    stage_d    = {stage_q[1:0], bus.din};
                    complete   = (samp_cnt_q == 2'd3);
                end else begin
                    div_cnt_d  = div_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end

        if (complete) begin
            if (!win_valid_q || bus.win_ready) begin
                win_d       = new_win;
                ones_d      = new_ones;
                vote_d      = (new_ones >= 3'd3);
                win_valid_d = 1'b1;
            end else begin
                overrun_d   = 1'b1;
            end
        end else if (win_valid_q && bus.win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            samp_cnt_q  <= '0;
            stage_q     <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            vote_q      <= 1'b0;
            ones_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            stage_q     <= stage_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            vote_q      <= vote_d;
            ones_q      <= ones_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.win       = win_q;
    assign bus.win_valid = win_valid_q;
    assign bus.vote      = vote_q;
    assign bus.ones      = ones_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_majority_window_sampler.sv
// ---------------------------------------------------------------------------
// tb_majority_window_sampler
//   Drives two samplers (DIV=4 and DIV=1) from one stimulus stream. A
//   behavioural model counts FILL cycles and collects samples in a list;
//   every window it expects the DUT to present is queued, and a monitor per
//   DUT pops and compares whenever a fresh window appears on the outputs.
// ---------------------------------------------------------------------------
module tb_majority_window_sampler;

    typedef struct packed {
        logic [3:0] win;
        logic [2:0] ones;
        logic       vote;
    } winExp_t;

    logic clk;
    logic rst;

    majority_window_sampler_if bus0 ();
    majority_window_sampler_if bus1 ();

    majority_window_sampler #(.DIV(4), .CNT_W(8)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    majority_window_sampler #(.DIV(1), .CNT_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    int testsRun  = 0;
    int failCount = 0;

    // Reference model state, one slot per DUT.
    winExp_t expQ0[$];
    winExp_t expQ1[$];
    int      divOf[2];
    bit      inFill[2];
    int      fillCount[2];
    int      nSamp[2];
    bit      samp[2][4];
    bit      mValid[2];
    bit      mOverrun[2];
    bit [3:0] mWin[2];
    bit      prevValid[2];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void compareVal(input string name, input int k,
                                       input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endfunction

    // One clock edge of the behavioural model: FILL cycles are counted from
    // entry, every DIV-th one takes a sample, and four samples form a window.
    function automatic void modelStep(input int k, input bit r, input bit en,
                                      input bit d, input bit rd, input bit clr);
        bit      done;
        bit      setOv;
        bit [3:0] w;
        winExp_t e;
        done  = 1'b0;
        setOv = 1'b0;
        w     = '0;
        if (r) begin
            inFill[k]    = 1'b0;
            fillCount[k] = 0;
            nSamp[k]     = 0;
            mValid[k]    = 1'b0;
            mOverrun[k]  = 1'b0;
            mWin[k]      = '0;
            return;
        end
        if (inFill[k]) begin
            if (en) begin
                fillCount[k]++;
                if (fillCount[k] % divOf[k] == 0) begin
                    samp[k][nSamp[k]] = d;
                    nSamp[k]++;
                    if (nSamp[k] == 4) begin
                        done     = 1'b1;
                        w        = {samp[k][0], samp[k][1], samp[k][2], samp[k][3]};
                        nSamp[k] = 0;
                    end
                end
            end else begin
                inFill[k] = 1'b0;
                nSamp[k]  = 0;
            end
        end else if (en) begin
            inFill[k]    = 1'b1;
            fillCount[k] = 0;
            nSamp[k]     = 0;
        end
        if (done) begin
            if (!mValid[k] || rd) begin
                mWin[k]   = w;
                mValid[k] = 1'b1;
                e.win     = w;
                e.ones    = 3'($countones(w));
                e.vote    = ($countones(w) >= 3);
                if (k == 0) expQ0.push_back(e);
                else        expQ1.push_back(e);
            end else begin
                setOv = 1'b1;
            end
        end else if (mValid[k] && rd) begin
            mValid[k] = 1'b0;
        end
        if (setOv)    mOverrun[k] = 1'b1;
        else if (clr) mOverrun[k] = 1'b0;
    endfunction

    // Predicts whether the next edge completes a window (used to pulse ready).
    function automatic bit willComplete(input int k, input bit en);
        return inFill[k] && en && (nSamp[k] == 3) && ((fillCount[k] + 1) % divOf[k] == 0);
    endfunction

    // Monitor body: runs just after each edge, pops on each fresh window.
    function automatic void checkOutput(input int k, input logic [3:0] win, input logic valid,
                                        input logic [2:0] ones, input logic vote,
                                        input logic ov, input logic rdy);
        bit      accepted;
        bit      newWin;
        winExp_t e;
        accepted = prevValid[k] && (rdy === 1'b1);
        newWin   = (valid === 1'b1) && (!prevValid[k] || accepted);
        compareVal("win_valid", k, 32'(valid), 32'(mValid[k]));
        compareVal("overrun",   k, 32'(ov),    32'(mOverrun[k]));
        if (newWin) begin
            if ((k == 0 && expQ0.size() == 0) || (k == 1 && expQ1.size() == 0)) begin
                testsRun++;
                failCount++;
                $display("[TB] FAIL window_pop dut%0d: got window %0h expected none at %0t", k, win, $time);
            end else begin
                e = (k == 0) ? expQ0.pop_front() : expQ1.pop_front();
                compareVal("win",  k, 32'(win),  32'(e.win));
                compareVal("ones", k, 32'(ones), 32'(e.ones));
                compareVal("vote", k, 32'(vote), 32'(e.vote));
            end
        end else if (valid === 1'b1) begin
            compareVal("held_win", k, 32'(win), 32'(mWin[k]));
        end
        prevValid[k] = (valid === 1'b1);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            checkOutput(0, bus0.win, bus0.win_valid, bus0.ones, bus0.vote, bus0.overrun, bus0.win_ready);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            checkOutput(1, bus1.win, bus1.win_valid, bus1.ones, bus1.vote, bus1.overrun, bus1.win_ready);
        end
    end

    // Drives one edge worth of inputs, steps the model, waits to the negedge.
    task automatic applyStimulus(input bit r, input bit en, input bit d,
                                 input bit rd0, input bit rd1, input bit clr);
        rst              = r;
        bus0.enable      = en;
        bus1.enable      = en;
        bus0.din         = d;
        bus1.din         = d;
        bus0.win_ready   = rd0;
        bus1.win_ready   = rd1;
        bus0.clr_overrun = clr;
        bus1.clr_overrun = clr;
        modelStep(0, r, en, d, rd0, clr);
        modelStep(1, r, en, d, rd1, clr);
        @(negedge clk);
    endtask

    // Holds each bit of a window for one DIV=4 sample interval.
    task automatic sendWindow(input bit [3:0] bits, input bit rd0, input int skip);
        for (int c = skip; c < 16; c++) begin
            applyStimulus(1'b0, 1'b1, bits[3 - c / 4], rd0, 1'b1, 1'b0);
        end
    endtask

    task automatic checkWindow0(input string tag, input bit [3:0] w, input bit [2:0] o, input bit v);
        compareVal({tag, "_valid"}, 0, 32'(bus0.win_valid), 32'(1));
        compareVal({tag, "_win"},   0, 32'(bus0.win),       32'(w));
        compareVal({tag, "_ones"},  0, 32'(bus0.ones),      32'(o));
        compareVal({tag, "_vote"},  0, 32'(bus0.vote),      32'(v));
    endtask

    initial begin
        bit r, en, d, rd0, rd1, clr;
        divOf = '{4, 1};
        for (int k = 0; k < 2; k++) begin
            inFill[k] = 0; fillCount[k] = 0; nSamp[k] = 0;
            mValid[k] = 0; mOverrun[k] = 0; mWin[k] = '0; prevValid[k] = 0;
        end

        // Reset in the middle of activity, with every other input asserted.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2)  applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        compareVal("rst_valid",   0, 32'(bus0.win_valid), 32'(0));
        compareVal("rst_win",     0, 32'(bus0.win),       32'(0));
        compareVal("rst_ones",    0, 32'(bus0.ones),      32'(0));
        compareVal("rst_vote",    0, 32'(bus0.vote),      32'(0));
        compareVal("rst_overrun", 1, 32'(bus1.overrun),   32'(0));

        // Clean window, then one-cycle valid, tie, and all-ones windows.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        sendWindow(4'b1101, 1'b1, 0);
        checkWindow0("clean", 4'b1101, 3'd3, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        compareVal("one_cycle_valid", 0, 32'(bus0.win_valid), 32'(0));
        sendWindow(4'b1100, 1'b1, 1);
        checkWindow0("tie", 4'b1100, 3'd2, 1'b0);
        sendWindow(4'b1111, 1'b1, 0);
        checkWindow0("all_ones", 4'b1111, 3'd4, 1'b1);

        // Back-pressure across eight samples, clear, then late accept.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        sendWindow(4'b0110, 1'b0, 1);
        checkWindow0("bp_first", 4'b0110, 3'd2, 1'b0);
        compareVal("bp_no_overrun_yet", 0, 32'(bus0.overrun), 32'(0));
        sendWindow(4'b1011, 1'b0, 0);
        checkWindow0("bp_held", 4'b0110, 3'd2, 1'b0);
        compareVal("bp_overrun", 0, 32'(bus0.overrun), 32'(1));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        compareVal("bp_cleared", 0, 32'(bus0.overrun), 32'(0));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        compareVal("bp_accepted", 0, 32'(bus0.win_valid), 32'(0));

        // Abort after two samples; the next window holds only fresh samples.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        sendWindow(4'b0001, 1'b1, 0);
        checkWindow0("abort", 4'b0001, 3'd1, 1'b0);

        // DIV=1 sampler with ready pulsed only on completion edges.
        for (int c = 0; c < 40; c++) begin
            d = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, 1'b1, d, 1'b1, willComplete(1, 1'b1), (c == 0));
        end
        compareVal("div1_valid_held", 1, 32'(bus1.win_valid), 32'(1));
        compareVal("div1_no_overrun", 1, 32'(bus1.overrun),   32'(0));

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            r   = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 31) != 0);
            d   = 1'($urandom_range(0, 1));
            rd0 = ($urandom_range(0, 3) != 0);
            rd1 = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 15) == 0);
            applyStimulus(r, en, d, rd0, rd1, clr);
        end

        compareVal("queue0_drained", 0, 32'(expQ0.size()), 32'(0));
        compareVal("queue1_drained", 1, 32'(expQ1.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
